// File: rtl/secure_pkg.sv
// secure_pkg: shared FSM encoding, default limits and fail-count helper for the secure read port
package secure_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, RESP, LOCKED} state_t;
  localparam int DEF_MAX_FAILS = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;
  // next fail count after a response: clear on grant, saturating increment on denial
  function automatic logic [2:0] fail_next(input logic [2:0] f, input logic err, input logic [2:0] max);
    return err ? ((f == max) ? f : f + 3'd1) : 3'd0;
  endfunction
endpackage

// File: rtl/secure_read_port_if.sv
// secure_read_port_if: request/response bus between a reader and the secure read port
interface secure_read_port_if;
  logic        rd_req;
  logic        rd_req_ready;
  logic        rd_priv;
  logic [31:0] sec_data;
  logic        sec_lock;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        locked_out;
  modport master (output rd_req, rd_priv, sec_data, sec_lock, rd_resp_ready,
                  input  rd_req_ready, rd_resp_valid, rd_data, rd_err, locked_out);
  modport slave  (input  rd_req, rd_priv, sec_data, sec_lock, rd_resp_ready,
                  output rd_req_ready, rd_resp_valid, rd_data, rd_err, locked_out);
endinterface

// File: rtl/secure_read_port_lockout_timer.sv
// lockout_timer: down-counter timing the LOCKED state, done when it reaches zero
module lockout_timer
  import secure_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic done
);
  localparam logic [7:0] LD = 8'(LOCKOUT_CYCLES - 1);
  logic [7:0] r_cnt;
  // load on lockout entry, count down to zero, clear on exit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (load) r_cnt <= LD;
    else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end
  assign done = (r_cnt == 8'd0);
endmodule

// File: rtl/secure_read_port.sv
// secure_read_port: privilege-checked read of a secret register with fail-count lockout
module secure_read_port
  import secure_pkg::*;
#(
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input logic             clk,
  input logic             rst,
  secure_read_port_if.slave bus
);
  localparam logic [2:0] MF = 3'(MAX_FAILS);
  state_t      r_state, w_next;
  logic        r_priv, r_err;
  logic [31:0] r_data;
  logic [2:0]  r_fails, w_fails_nxt;
  logic        w_grant, w_resp_hs, w_load, w_clear, w_done, w_valid;
  assign w_grant     = r_priv & ~bus.sec_lock;
  assign w_resp_hs   = (r_state == RESP) & bus.rd_resp_ready;
  assign w_fails_nxt = fail_next(r_fails, r_err, MF);
  assign w_load      = w_resp_hs & (w_fails_nxt == MF);
  assign w_clear     = (r_state == LOCKED) & w_done;
  assign w_valid     = (r_state == RESP);
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state logic: requests only in IDLE, response held until consumed
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.rd_req ? CHECK : IDLE;
      CHECK:   w_next = RESP;
      RESP:    w_next = !bus.rd_resp_ready ? RESP : (w_load ? LOCKED : IDLE);
      LOCKED:  w_next = w_done ? IDLE : LOCKED;
      default: w_next = IDLE;
    endcase
  end
  // capture privilege, latch the checked response and track consecutive denials
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_priv  <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_fails <= '0;
    end else begin
      if (r_state == IDLE && bus.rd_req) r_priv <= bus.rd_priv;
      if (r_state == CHECK) begin
        r_data <= w_grant ? bus.sec_data : '0;
        r_err  <= ~w_grant;
      end
      if (w_resp_hs) begin
        r_fails <= w_fails_nxt;
        r_data  <= '0;
        r_err   <= 1'b0;
      end
      if (w_clear) r_fails <= '0;
    end
  end
  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .clear (w_clear),
    .done  (w_done)
  );
  assign bus.rd_req_ready  = (r_state == IDLE);
  assign bus.rd_resp_valid = w_valid;
  assign bus.rd_data       = w_valid ? r_data : '0;
  assign bus.rd_err        = w_valid & r_err;
  assign bus.locked_out    = (r_state == LOCKED);
endmodule

// File: tb/tb_secure_read_port.sv
// tb_secure_read_port: directed vector bench for the secure read port
module tb_secure_read_port;
  logic clk, rst;
  int checks = 0, failures = 0;
  secure_read_port_if bus();
  secure_read_port #(.MAX_FAILS(3), .LOCKOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic        p, l;
    logic [31:0] d, ed;
    logic        ee, el;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic rd(input logic p, input logic l, input logic [31:0] d, input logic [31:0] ed,
                    input logic ee, input logic el);
    chk("idle_ready", 32'(bus.rd_req_ready), 32'd1);
    bus.rd_req = 1'b1; bus.rd_priv = p; bus.sec_lock = l; bus.sec_data = d; bus.rd_resp_ready = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.rd_priv = ~p;
    chk("check_valid", 32'(bus.rd_resp_valid), 32'd0);
    chk("check_data", bus.rd_data, 32'd0);
    chk("check_ready", 32'(bus.rd_req_ready), 32'd0);
    @(negedge clk);
    bus.sec_lock = ~l; bus.sec_data = ~d;
    chk("resp_valid", 32'(bus.rd_resp_valid), 32'd1);
    chk("resp_data", bus.rd_data, ed);
    chk("resp_err", 32'(bus.rd_err), 32'(ee));
    @(negedge clk);
    chk("post_valid", 32'(bus.rd_resp_valid), 32'd0);
    chk("post_data", bus.rd_data, 32'd0);
    chk("post_err", 32'(bus.rd_err), 32'd0);
    chk("post_locked", 32'(bus.locked_out), 32'(el));
  endtask
  initial begin
    int n;
    v[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    v[1] = '{1'b0, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0};
    v[2] = '{1'b1, 1'b1, 32'h12345678, 32'h0,        1'b1, 1'b0};
    v[3] = '{1'b1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
    v[4] = '{1'b0, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0};
    v[5] = '{1'b0, 1'b1, 32'h5A5A5A5A, 32'h0,        1'b1, 1'b0};
    v[6] = '{1'b0, 1'b0, 32'hCAFEF00D, 32'h0,        1'b1, 1'b1};
    bus.rd_req = 1'b0; bus.rd_priv = 1'b0; bus.sec_data = '0; bus.sec_lock = 1'b0; bus.rd_resp_ready = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rd_resp_valid), 32'd0);
    chk("rst_data", bus.rd_data, 32'd0);
    chk("rst_locked", 32'(bus.locked_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rel_ready", 32'(bus.rd_req_ready), 32'd1);
    for (int i = 0; i < 7; i++) rd(v[i].p, v[i].l, v[i].d, v[i].ed, v[i].ee, v[i].el);
    n = 0;
    while (bus.locked_out && n < 100) begin
      chk("lock_ready", 32'(bus.rd_req_ready), 32'd0);
      bus.rd_req = (n == 3 || n == 4); bus.rd_priv = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("lock_len", n, 32'd16);
    chk("unlock_ready", 32'(bus.rd_req_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("no_queued_req", 32'(bus.rd_resp_valid), 32'd0);
    end
    rd(1'b1, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0);
    bus.rd_req = 1'b1; bus.rd_priv = 1'b1; bus.sec_lock = 1'b0; bus.sec_data = 32'h11112222; bus.rd_resp_ready = 1'b0;
    @(negedge clk);
    bus.rd_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.sec_data = $urandom;
      chk("bp_valid", 32'(bus.rd_resp_valid), 32'd1);
      chk("bp_data", bus.rd_data, 32'h11112222);
      @(negedge clk);
    end
    bus.rd_resp_ready = 1'b1;
    chk("bp_last_data", bus.rd_data, 32'h11112222);
    @(negedge clk);
    chk("bp_done_valid", 32'(bus.rd_resp_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.rd_req_ready), 32'd1);
    rd(1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    rd(1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    rd(1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1);
    repeat (7) @(negedge clk);
    chk("lock_cycle8", 32'(bus.locked_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midlock_rst_locked", 32'(bus.locked_out), 32'd0);
    chk("midlock_rst_valid", 32'(bus.rd_resp_valid), 32'd0);
    chk("midlock_rst_data", bus.rd_data, 32'd0);
    chk("midlock_rst_err", 32'(bus.rd_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("midlock_rel_ready", 32'(bus.rd_req_ready), 32'd1);
    rd(1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    rd(1'b0, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/secure_read_port.md
SECURE_READ_PORT -- requirements
Module: secure_read_port

Interface
REQ-001 The block SHALL have parameter MAX_FAILS, default 3: consecutive denied reads that trigger lockout (range 1..7).
REQ-002 The block SHALL have parameter LOCKOUT_CYCLES, default 16: duration of the LOCKED state in clk cycles (range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port rd_req, input, 1 bit: read request valid.
REQ-006 The block SHALL have port rd_req_ready, output, 1 bit: request accepted when rd_req and rd_req_ready are both high.
REQ-007 The block SHALL have port rd_priv, input, 1 bit: requester privilege, sampled with the request.
REQ-008 The block SHALL have port sec_data, input, 32 bits: the sensitive register value from the write-side block.
REQ-009 The block SHALL have port sec_lock, input, 1 bit: system lock; when high, all reads are denied.
REQ-010 The block SHALL have port rd_resp_valid, output, 1 bit: response valid.
REQ-011 The block SHALL have port rd_resp_ready, input, 1 bit: response consumed when rd_resp_valid and rd_resp_ready are both high.
REQ-012 The block SHALL have port rd_data, output, 32 bits: read data, zero unless granted.
REQ-013 The block SHALL have port rd_err, output, 1 bit: access denied flag, valid with rd_resp_valid.
REQ-014 The block SHALL have port locked_out, output, 1 bit: high while in the LOCKED state.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, CHECK, RESP and LOCKED.
REQ-016 rd_req_ready SHALL be high only in IDLE; requests in any other state SHALL be ignored and SHALL NOT be queued.
REQ-017 On a request handshake in IDLE (cycle T), the block SHALL capture rd_priv and move to CHECK at T+1.
REQ-018 In CHECK, grant SHALL equal captured rd_priv AND NOT sec_lock, with sec_lock sampled in this cycle only.
REQ-019 When grant is high, the block SHALL capture sec_data into the response register; when grant is low, it SHALL capture zero and set the error bit. It then moves to RESP.
REQ-020 In RESP (from T+2), rd_resp_valid SHALL be high, and rd_data and rd_err SHALL stay stable until the response handshake.
REQ-021 Minimum request-to-response latency SHALL be 2 cycles; with rd_resp_ready held high, a new request SHALL be acceptable at T+3.
REQ-022 rd_data SHALL be 32'h0 and rd_err SHALL be 0 whenever rd_resp_valid is low; secret data SHALL never appear outside a granted RESP.
REQ-023 A granted response SHALL clear the fail counter; a denied response SHALL increment it, saturating at MAX_FAILS.
REQ-024 The fail counter SHALL update at the response handshake, not in CHECK.
REQ-025 On the response handshake, the block SHALL go to LOCKED if the updated fail count equals MAX_FAILS, else to IDLE.
REQ-026 On entering LOCKED, the lockout counter SHALL load LOCKOUT_CYCLES-1 and decrement each cycle.
REQ-027 At lockout count 0, the block SHALL clear the fail counter and go to IDLE; LOCKED SHALL last exactly LOCKOUT_CYCLES cycles.
REQ-028 locked_out SHALL equal (state == LOCKED); rd_req_ready SHALL be 0 throughout LOCKED.
REQ-029 If rd_resp_ready is high on the first RESP cycle, the response SHALL complete in that cycle; back-pressure SHALL hold RESP indefinitely.
REQ-030 sec_data changes after CHECK SHALL NOT alter a pending response.

Reset
REQ-031 Asserting rst SHALL immediately force: state IDLE, fail counter 0, lockout counter 0, response register 0, rd_resp_valid 0, rd_err 0, rd_data 0, locked_out 0.
REQ-032 rd_req_ready SHALL be 1 from the first cycle after reset release.
REQ-033 Reset mid-RESP or mid-LOCKED SHALL discard the response and abort the lockout, with no residual fail count.

Structure
REQ-034 The state encoding typedef and the default MAX_FAILS/LOCKOUT_CYCLES constants SHALL live in shared package secure_pkg.
REQ-035 The lockout down-counter SHALL be implemented as sub-module lockout_timer (inputs: load, clear; output: done).

Verification
REQ-036 Granted read: rd_priv=1, sec_lock=0, sec_data=32'hDEADBEEF, rd_resp_ready=1 -> rd_resp_valid at T+2, rd_data=32'hDEADBEEF, rd_err=0.
REQ-037 Denied read: rd_priv=0, sec_data=32'hCAFEF00D -> rd_data=0, rd_err=1; the secret never appears on rd_data in any cycle.
REQ-038 Lockout: 3 denied reads -> locked_out high for exactly 16 cycles with rd_req_ready=0; a 4th rd_req during lockout is ignored; the next request is accepted after lockout ends.
REQ-039 Counter clear: 2 denials, 1 grant, then 2 denials -> no lockout.
REQ-040 Back-pressure: rd_resp_ready=0 for 5 cycles and sec_data changed during RESP -> rd_data holds the CHECK-sampled value; the handshake completes on the first ready cycle.
REQ-041 Reset during LOCKED (cycle 8) -> all outputs 0, rd_req_ready=1 after release, and a granted read succeeds.
